qarctan_arbiter: RTL and testbench
==================================

Name: qarctan_arbiter

Overview:
Shares one qarctan (arctangent/divider) unit between two demodulation channels, e.g. mono demod and a second stereo/pilot demod path. Each channel raises a request with its 32-bit x/y operands. The arbiter grants round-robin, issues a single start pulse to qarctan and waits for qarctan done. It then returns the result only to the channel that owns the transaction. It sits between the demod channel front ends and the single qarctan instance.

Parameters:
NUM_REQ, 2, number of requesting channels (only 2 supported; indices 0 and 1)
DATA_WIDTH, 32, width of x, y and result words
TIMEOUT_CYCLES, 1024, watchdog limit in BUSY (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  2  per-channel request; held high with operands stable until the matching ack
x0  in  32  channel 0 real operand (signed)
y0  in  32  channel 0 imaginary operand (signed)
x1  in  32  channel 1 real operand (signed)
y1  in  32  channel 1 imaginary operand (signed)
ack  out  2  one-cycle pulse: operands of channel i accepted
result  out  32  qarctan output of the completed transaction
result_valid  out  2  one-cycle pulse on the owning channel's bit; result valid that cycle
qarc_valid  out  1  start pulse to qarctan (its demod_data_valid input)
qarc_x  out  32  operand x to qarctan
qarc_y  out  32  operand y to qarctan
qarc_ready  in  1  qarctan/divider ready
qarc_data  in  32  qarctan data_out
qarc_done  in  1  qarctan completion pulse
busy  out  1  high whenever state is not IDLE
timeout_err  out  1  sticky watchdog flag (optional feature only; tied 0 otherwise)

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high.
- All outputs are registered.
- Reset values: ack=0, result=0, result_valid=0, qarc_valid=0, qarc_x=0, qarc_y=0, busy=0, timeout_err=0. State=IDLE, rr pointer=0 (channel 0 has priority), owner=0.
- States:
  - IDLE: entered on reset and after RETURN.
  - ISSUE: drives the start pulse.
  - BUSY: waits for qarctan.
  - RETURN: delivers the result.
- IDLE:
  - Stays in IDLE if req==0 or qarc_ready==0.
  - Otherwise selects a winner. If only one req bit is set, that channel wins. If both are set, the channel at the rr pointer wins.
  - Latches the winner's x/y into qarc_x/qarc_y and records owner.
  - ack[owner]=1 in the next cycle; moves to ISSUE.
- ISSUE: qarc_valid=1 for exactly one cycle with stable qarc_x/qarc_y, then moves to BUSY.
- BUSY:
  - Waits for qarc_done=1.
  - On done, captures qarc_data into result and moves to RETURN.
  - qarc_x/qarc_y stay stable throughout BUSY.
- RETURN:
  - result_valid[owner]=1 for one cycle with result.
  - rr pointer = ~owner.
  - Moves to IDLE.
- result holds its value until the next capture.
- Latency: req seen in IDLE -> ack after 1 cycle -> qarc_valid after 2 cycles -> result_valid 1 cycle after qarc_done is sampled in BUSY.
- Minimum transaction is 4 cycles plus the qarctan latency.
- Requester rules:
  - The requester drops req or changes operands only after seeing ack.
  - A req still high after ack is treated as a new request on the next IDLE.
- Boundary conditions:
  - qarc_done outside BUSY is ignored (no capture, no result_valid).
  - qarc_ready low in IDLE stalls the grant, with no ack.
  - A req arriving during ISSUE/BUSY/RETURN waits; it is not dropped, since it is held by the requester.
  - Both channels continuously requesting alternate strictly: 0, 1, 0, 1, ...
  - The result is raw 32-bit qarctan data; no scaling or dequantization here. The gain is applied downstream.
  - Reset mid-transaction: immediate return to reset values and the in-flight result is discarded. A late qarc_done is ignored because the state is IDLE.

Optional Feature:
- Macro: QARCTAN_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in BUSY and is cleared on entry to BUSY.
  - If the counter reaches TIMEOUT_CYCLES without qarc_done: result=32'h0, move to RETURN and pulse result_valid[owner] as normal.
  - Sets timeout_err=1 (sticky until reset).
- When undefined: no counter, BUSY waits indefinitely, timeout_err is constant 0.

Test Plan:
- Single request: req=01, x0=32'h400, y0=32'h0, qarc_ready=1, model qarctan returns 32'h0 after 10 cycles -> ack=01 one cycle later, exactly one qarc_valid with qarc_x=32'h400, qarc_y=0, then result_valid=01 with result=0; busy low afterwards.
- Simultaneous: req=11 from reset for 4 transactions, qarctan returns 32'h324 -> grants in order 0, 1, 0, 1; ack and result_valid never both bits high; each result=32'h324.
- Stall: req=10, qarc_ready=0 for 20 cycles then 1 -> no ack or qarc_valid during the stall; ack=10 one cycle after ready rises.
- Stray done: pulse qarc_done in IDLE and ISSUE -> no result_valid, result unchanged; the proper done in BUSY with 32'hFFFFFCDC yields result=32'hFFFFFCDC.
- Reset mid-BUSY: assert reset for 1 cycle while busy, then deliver qarc_done -> all outputs at reset values, no result_valid; the next req=01 is served by channel 0.
- With QARCTAN_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, qarctan never completes -> result_valid[owner] after 16 BUSY cycles with result=0 and timeout_err=1, which stays 1 until reset.

Source files
------------

// File: rtl/qarctan_arbiter.sv
// Round-robin arbiter sharing one qarctan unit between two demod channels.
// Define QARCTAN_ARB_TIMEOUT_EN to enable the BUSY watchdog and sticky timeout_err.

module qarctan_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] y0,
    input  logic [DATA_WIDTH-1:0] x1,
    input  logic [DATA_WIDTH-1:0] y1,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DATA_WIDTH-1:0] result,
    output logic [NUM_REQ-1:0]    result_valid,
    output logic                  qarc_valid,
    output logic [DATA_WIDTH-1:0] qarc_x,
    output logic [DATA_WIDTH-1:0] qarc_y,
    input  logic                  qarc_ready,
    input  logic [DATA_WIDTH-1:0] qarc_data,
    input  logic                  qarc_done,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t                state_r;
    logic                  rr_r;
    logic                  owner_r;
    logic                  grant_s;
    logic                  win_s;
    logic [DATA_WIDTH-1:0] win_x_s;
    logic [DATA_WIDTH-1:0] win_y_s;

    function automatic logic [NUM_REQ-1:0] onehot_f(input logic ch);
        onehot_f = ch ? 2'b10 : 2'b01;
    endfunction

    // The channel decode below is hard-wired for exactly two requesters.
    generate
        if (NUM_REQ != 32'sd2 || TIMEOUT_CYCLES < 32'sd1) begin : g_bad_cfg
            $error("qarctan_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
        end
    endgenerate

`ifdef QARCTAN_ARB_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 32'sd1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 32'sd1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             tmo_err_r;

    assign timeout_err = tmo_err_r;
`else
    assign timeout_err = 1'b0;
`endif

    // Winner selection: a lone requester wins, a tie goes to the rr pointer.
    always_comb begin
        grant_s = 1'b0;
        win_s   = 1'b0;
        if (qarc_ready && (|req)) begin
            grant_s = 1'b1;
            if (req[0] && req[1]) begin
                win_s = rr_r;
            end else begin
                win_s = req[1];
            end
        end else begin
            grant_s = 1'b0;
        end
        win_x_s = win_s ? x1 : x0;
        win_y_s = win_s ? y1 : y0;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            rr_r         <= 1'b0;
            owner_r      <= 1'b0;
            ack          <= {NUM_REQ{1'b0}};
            result       <= {DATA_WIDTH{1'b0}};
            result_valid <= {NUM_REQ{1'b0}};
            qarc_valid   <= 1'b0;
            qarc_x       <= {DATA_WIDTH{1'b0}};
            qarc_y       <= {DATA_WIDTH{1'b0}};
            busy         <= 1'b0;
`ifdef QARCTAN_ARB_TIMEOUT_EN
            tmo_cnt_r    <= {TMO_W{1'b0}};
            tmo_err_r    <= 1'b0;
`endif
        end else begin
            ack          <= {NUM_REQ{1'b0}};
            result_valid <= {NUM_REQ{1'b0}};
            qarc_valid   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        owner_r <= win_s;
                        qarc_x  <= win_x_s;
                        qarc_y  <= win_y_s;
                        ack     <= onehot_f(win_s);
                        busy    <= 1'b1;
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    qarc_valid <= 1'b1;
                    state_r    <= ST_BUSY;
`ifdef QARCTAN_ARB_TIMEOUT_EN
                    tmo_cnt_r  <= {TMO_W{1'b0}};
`endif
                end
                ST_BUSY: begin
                    if (qarc_done) begin
                        result       <= qarc_data;
                        result_valid <= onehot_f(owner_r);
                        state_r      <= ST_RETURN;
                    end
`ifdef QARCTAN_ARB_TIMEOUT_EN
                    else if (tmo_cnt_r == TMO_LAST) begin
                        result       <= {DATA_WIDTH{1'b0}};
                        result_valid <= onehot_f(owner_r);
                        tmo_err_r    <= 1'b1;
                        state_r      <= ST_RETURN;
                    end else begin
                        tmo_cnt_r    <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
`else
                    else begin
                        state_r      <= ST_BUSY;
                    end
`endif
                end
                ST_RETURN: begin
                    rr_r    <= ~owner_r;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qarctan_arbiter.sv
// Randomized self-checking bench for qarctan_arbiter against a transaction-level model.
// Define QARCTAN_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).

module tb_qarctan_arbiter;

`ifdef QARCTAN_ARB_TIMEOUT_EN
    localparam int TB_TMO = 16;
`else
    localparam int TB_TMO = 1024;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] xs [2];
    logic [31:0] ys [2];
    logic [31:0] x0, y0, x1, y1;
    logic [1:0]  ack;
    logic [31:0] result;
    logic [1:0]  result_valid;
    logic        qarc_valid;
    logic [31:0] qarc_x, qarc_y;
    logic        qarc_ready;
    logic [31:0] qarc_data;
    logic        qarc_done;
    logic        busy;
    logic        timeout_err;

    int          n_checks;
    int          n_errors;
    bit          model_pri;
    logic [31:0] last_result;
    bit          exp_tmo_err;

    assign x0 = xs[0];
    assign y0 = ys[0];
    assign x1 = xs[1];
    assign y1 = ys[1];

    qarctan_arbiter #(
        .NUM_REQ        (2),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TB_TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .x0           (x0),
        .y0           (y0),
        .x1           (x1),
        .y1           (y1),
        .ack          (ack),
        .result       (result),
        .result_valid (result_valid),
        .qarc_valid   (qarc_valid),
        .qarc_x       (qarc_x),
        .qarc_y       (qarc_y),
        .qarc_ready   (qarc_ready),
        .qarc_data    (qarc_data),
        .qarc_done    (qarc_done),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "simulation time limit");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ack"},  32'(ack),          32'd0);
        check_val({tag, "_res"},  result,            32'd0);
        check_val({tag, "_rv"},   32'(result_valid), 32'd0);
        check_val({tag, "_qv"},   32'(qarc_valid),   32'd0);
        check_val({tag, "_qx"},   qarc_x,            32'd0);
        check_val({tag, "_qy"},   qarc_y,            32'd0);
        check_val({tag, "_busy"}, 32'(busy),         32'd0);
        check_val({tag, "_terr"}, 32'(timeout_err),  32'd0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req        = 2'b00;
        qarc_done  = 1'b0;
        qarc_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset       = 1'b0;
        model_pri   = 1'b0;
        last_result = 32'd0;
        exp_tmo_err = 1'b0;
        check_idle_outputs("reset");
    endtask

    // One transaction; starts and ends on a negedge with the arbiter idle.
    task automatic run_txn(input logic [1:0] new_req, input int stall, input int lat,
                           input logic [31:0] data, input bit stray, input bit expect_tmo);
        bit          win;
        logic [1:0]  exp_ack;
        logic [31:0] exp_x, exp_y, exp_res;
        req     = req | new_req;
        win     = (req == 2'b11) ? model_pri : req[1];
        exp_ack = win ? 2'b10 : 2'b01;
        exp_x   = xs[win];
        exp_y   = ys[win];
        qarc_ready = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            qarc_done = stray && (i % 2 == 0);
            qarc_data = $urandom;
            @(negedge clk);
            check_val("stall_ack",  32'(ack),          32'd0);
            check_val("stall_qv",   32'(qarc_valid),   32'd0);
            check_val("stall_rv",   32'(result_valid), 32'd0);
            check_val("stall_busy", 32'(busy),         32'd0);
            check_val("stall_res",  result,            last_result);
            if (i == stall - 1) qarc_ready = 1'b1;
        end
        qarc_done = 1'b0;
        @(negedge clk);
        check_val("ack",      32'(ack),        32'(exp_ack));
        check_val("busy_run", 32'(busy),       32'd1);
        check_val("qv_early", 32'(qarc_valid), 32'd0);
        req[win] = 1'b0;
        xs[win]  = $urandom;
        ys[win]  = $urandom;
        if (stray) begin
            qarc_done = 1'b1;
            qarc_data = $urandom;
        end
        @(negedge clk);
        qarc_done = 1'b0;
        check_val("qv",        32'(qarc_valid),   32'd1);
        check_val("qx",        qarc_x,            exp_x);
        check_val("qy",        qarc_y,            exp_y);
        check_val("ack_clear", 32'(ack),          32'd0);
        check_val("issue_rv",  32'(result_valid), 32'd0);
        check_val("issue_res", result,            last_result);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check_val("wait_qv", 32'(qarc_valid),   32'd0);
            check_val("wait_rv", 32'(result_valid), 32'd0);
            check_val("wait_qx", qarc_x,            exp_x);
            check_val("wait_qy", qarc_y,            exp_y);
        end
        if (expect_tmo) begin
            exp_res     = 32'd0;
            exp_tmo_err = 1'b1;
        end else begin
            qarc_done = 1'b1;
            qarc_data = data;
            exp_res   = data;
        end
        @(negedge clk);
        qarc_done = 1'b0;
        qarc_data = $urandom;
        check_val("rv",       32'(result_valid), 32'(exp_ack));
        check_val("res",      result,            exp_res);
        check_val("ret_busy", 32'(busy),         32'd1);
        check_val("terr",     32'(timeout_err),  32'(exp_tmo_err));
        model_pri   = ~win;
        last_result = exp_res;
        @(negedge clk);
        check_val("rv_clear",  32'(result_valid), 32'd0);
        check_val("idle_busy", 32'(busy),         32'd0);
        check_val("res_hold",  result,            last_result);
    endtask

    initial begin
        logic [1:0] nr;
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        req        = 2'b00;
        xs[0] = 32'd0; xs[1] = 32'd0;
        ys[0] = 32'd0; ys[1] = 32'd0;
        qarc_ready = 1'b1;
        qarc_data  = 32'd0;
        qarc_done  = 1'b0;
        @(negedge clk);
        do_reset();

        // Single request from channel 0.
        xs[0] = 32'h400;
        ys[0] = 32'h0;
        run_txn(2'b01, 0, 10, 32'h0, 1'b0, 1'b0);

        // Both channels requesting continuously alternate 0,1,0,1.
        do_reset();
        xs[0] = $urandom; ys[0] = $urandom;
        xs[1] = $urandom; ys[1] = $urandom;
        for (int k = 0; k < 4; k++) run_txn(2'b11, 0, $urandom_range(2, 6), 32'h324, 1'b0, 1'b0);

        // Grant stalled by qarc_ready low.
        do_reset();
        run_txn(2'b10, 20, 4, $urandom, 1'b0, 1'b0);

        // Stray done pulses in IDLE and ISSUE are ignored.
        run_txn(2'b01, 3, 5, 32'hFFFFFCDC, 1'b1, 1'b0);

        // Reset in the middle of BUSY discards the transaction and the late done.
        do_reset();
        run_txn(2'b01, 0, 3, $urandom, 1'b0, 1'b0);
        req = 2'b10;
        @(negedge clk);
        check_val("mid_ack", 32'(ack), 32'b10);
        req = 2'b00;
        @(negedge clk);
        check_val("mid_qv", 32'(qarc_valid), 32'd1);
        repeat (3) @(negedge clk);
        check_val("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        model_pri   = 1'b0;
        last_result = 32'd0;
        exp_tmo_err = 1'b0;
        check_idle_outputs("midrst");
        qarc_done = 1'b1;
        qarc_data = $urandom;
        @(negedge clk);
        qarc_done = 1'b0;
        check_val("late_rv",   32'(result_valid), 32'd0);
        check_val("late_res",  result,            32'd0);
        check_val("late_busy", 32'(busy),         32'd0);
        run_txn(2'b11, 0, 4, $urandom, 1'b0, 1'b0);

`ifdef QARCTAN_ARB_TIMEOUT_EN
        // qarctan never completes: watchdog returns 0 and latches timeout_err.
        do_reset();
        run_txn(2'b01, 0, TB_TMO - 1, 32'h0, 1'b0, 1'b1);
        run_txn(2'b10, 0, 3, $urandom, 1'b0, 1'b0);
        do_reset();
`endif

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            nr = 2'($urandom_range(1, 3));
            for (int ch = 0; ch < 2; ch++) begin
                if (nr[ch] && !req[ch]) begin
                    xs[ch] = $urandom;
                    ys[ch] = $urandom;
                end
            end
            run_txn(nr, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                    $urandom_range(0, 12), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
